dmem_bus: RTL and testbench
===========================

DMEM_BUS -- requirements
Module: dmem_bus

Interface
REQ-001 Parameter UART_DATA_ADDR, 16'hBF00, address of the UART data register.
REQ-002 Parameter UART_STAT_ADDR, 16'hBF01, address of the UART status register.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 req_i  in  1  MEM-stage access request; held high until done_o.
REQ-006 we_i  in  1  1 = write, 0 = read.
REQ-007 addr_i  in  16  word address from the EX/MEM ALU result.
REQ-008 wdata_i  in  16  store data.
REQ-009 rdata_o  out  16  load data returned to MEM/WB.
REQ-010 done_o  out  1  one-cycle completion pulse.
REQ-011 busy_o  out  1  stall request to the hazard unit.
REQ-012 Ram1Addr  out  18  SRAM address.
REQ-013 Ram1Data  inout  16  SRAM/UART shared data bus.
REQ-014 Ram1OE, Ram1WE, Ram1EN  out  1 each  SRAM controls, active-low.
REQ-015 rdn, wrn  out  1 each  UART read/write strobes, active-low.
REQ-016 data_ready, tbre, tsre  in  1 each  UART status inputs.

Function
REQ-017 States SHALL be IDLE, RD, WR_SETUP, WR_PULSE, U_RWAIT, U_RD, U_WWAIT, U_WR and DONE.
REQ-018 In IDLE with req_i=1, the block SHALL latch addr_i, we_i and wdata_i at the clock edge and branch on the latched address and we_i.
REQ-019 A request outside the two UART addresses SHALL go to SRAM, with Ram1Addr = {2'b00, latched addr}.
REQ-020 SRAM read SHALL follow IDLE->RD->DONE: Ram1EN=0 and Ram1OE=0 in RD; rdata_o is latched from Ram1Data on the RD->DONE edge; done_o is high 2 cycles after acceptance.
REQ-021 SRAM write SHALL follow IDLE->WR_SETUP->WR_PULSE->DONE: bus driven with wdata in all three states; Ram1WE=0 only in WR_PULSE; done_o is high 3 cycles after acceptance.
REQ-022 A UART_STAT_ADDR read SHALL go IDLE->DONE with rdata_o = {14'b0, data_ready, tbre&tsre} sampled at acceptance (latency 1).
REQ-023 A UART_DATA_ADDR read SHALL wait in U_RWAIT until data_ready=1, spend one cycle in U_RD with rdn=0, latch Ram1Data on exit, then enter DONE.
REQ-024 A UART_DATA_ADDR write SHALL wait in U_WWAIT until tbre=1 and tsre=1, spend one cycle in U_WR with wrn=0 and the bus driven, then enter DONE.
REQ-025 UART waits SHALL have no timeout.
REQ-026 Ram1EN SHALL be 1 in every UART state and in IDLE, so the SRAM never contends with the UART on the bus.
REQ-027 Ram1Data SHALL be high-Z except in WR_SETUP, WR_PULSE, U_WR, and DONE following a write.
REQ-028 A status write SHALL be discarded and go IDLE->DONE.
REQ-029 done_o SHALL be 1 only in DONE; DONE always returns to IDLE, and req_i is ignored in DONE.
REQ-030 Back-to-back requests SHALL therefore have a minimum of one IDLE cycle between them.
REQ-031 busy_o SHALL equal (req_i & ~done_o) | (state != IDLE & state != DONE).
REQ-032 rdata_o SHALL hold its value until the next read completes; writes leave it unchanged.
REQ-033 Deassertion of req_i mid-transaction SHALL be ignored; the transaction completes.

Reset
REQ-034 When rst=1 at a clock edge, the state SHALL become IDLE.
REQ-035 On that edge: Ram1OE=Ram1WE=Ram1EN=rdn=wrn=1, done_o=0, rdata_o=16'h0000, Ram1Addr=0, and the bus is released.
REQ-036 Reset during any state, including WR_PULSE and U_WR, SHALL abort the transaction, deassert the strobes on that edge, and produce no done_o.

Structure
REQ-037 The state encoding, UART_DATA_ADDR and UART_STAT_ADDR SHALL live in the shared CPU definitions package.
REQ-038 The block SHALL be a single module with one registered FSM and registered strobes, and no sub-module.
REQ-039 It SHALL be instantiated in zzcpu between ex_mem and mem_wb, replacing the direct Ram1 pins.

Verification
REQ-040 SRAM write then read: write addr 16'h0010, data 16'hABCD, then read 16'h0010 -> Ram1WE low exactly 1 cycle; done_o at +3 then +2; rdata_o = 16'hABCD.
REQ-041 UART write while busy: tbre=0 for 5 cycles, then 1, with tsre=1 -> state stays U_WWAIT and wrn stays high; wrn is low exactly 1 cycle after tbre rises; Ram1EN stays 1 throughout.
REQ-042 UART read: data_ready rises after 4 cycles, bus value 16'h0041 -> rdn low 1 cycle; rdata_o = 16'h0041.
REQ-043 Status read with data_ready=1, tbre=1, tsre=0 -> rdata_o = 16'h0002; done_o at +1.
REQ-044 Reset asserted in WR_PULSE -> Ram1WE=1 and bus high-Z on the next edge; no done_o; next request is accepted normally.
REQ-045 Bus contention checker: in every cycle, Ram1Data is never driven while Ram1OE=0 or rdn=0.

Source files
------------

// File: rtl/dmem_bus_pkg.sv
// Shared CPU definitions for the MEM-stage data bus.
// Provides the UART register addresses, the bus controller state encoding
// and a helper that packs the UART status word returned on a status read.
package dmem_bus_pkg;

    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

    typedef enum logic [3:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        U_RWAIT,
        U_RD,
        U_WWAIT,
        U_WR,
        DONE
    } dmem_state_e;

    // Bit 1: a received byte is waiting; bit 0: transmitter fully idle.
    function automatic logic [15:0] uart_status_word(input logic data_ready,
                                                     input logic tbre,
                                                     input logic tsre);
        return {14'b0, data_ready, tbre & tsre};
    endfunction

endpackage

// File: rtl/dmem_bus.sv
// dmem_bus: MEM-stage data access controller sharing one 16-bit bus between
// the external SRAM (Ram1) and the memory-mapped UART.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_i             access request, held high until done_o
//   we_i              1 = write, 0 = read
//   addr_i, wdata_i   word address and store data
//   rdata_o           load data, holds until the next read completes
//   done_o            one-cycle completion pulse
//   busy_o            stall request to the hazard unit
//   Ram1Addr          SRAM address
//   Ram1Data          shared SRAM/UART data bus (tri-state)
//   Ram1OE/WE/EN      SRAM controls, active-low
//   rdn, wrn          UART read/write strobes, active-low
//   data_ready, tbre, tsre  UART status inputs
module dmem_bus
    import dmem_bus_pkg::*;
#(
    parameter logic [15:0] UART_DATA_ADDR = dmem_bus_pkg::UART_DATA_ADDR,
    parameter logic [15:0] UART_STAT_ADDR = dmem_bus_pkg::UART_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        done_o,
    output logic        busy_o,
    output logic [17:0] Ram1Addr,
    inout  logic [15:0] Ram1Data,
    output logic        Ram1OE,
    output logic        Ram1WE,
    output logic        Ram1EN,
    output logic        rdn,
    output logic        wrn,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre
);

    dmem_state_e state_q, state_d;

    logic        accept;
    logic        we_q;
    logic        we_nxt;
    logic [15:0] wdata_q;
    logic        drive_q;

    logic        oe_n_d, we_n_d, en_n_d, rdn_d, wrn_d, drive_d;

    assign accept = (state_q == IDLE) && req_i;

    // Write flag as it will be after this edge; the DONE bus drive depends on it.
    assign we_nxt = accept ? we_i : we_q;

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (addr_i == UART_STAT_ADDR) begin
                        // Status reads complete at once; status writes are dropped.
                        state_d = DONE;
                    end else if (addr_i == UART_DATA_ADDR) begin
                        state_d = we_i ? U_WWAIT : U_RWAIT;
                    end else begin
                        state_d = we_i ? WR_SETUP : RD;
                    end
                end
            end
            RD:       state_d = DONE;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = DONE;
            U_RWAIT:  if (data_ready) state_d = U_RD;
            U_RD:     state_d = DONE;
            U_WWAIT:  if (tbre && tsre) state_d = U_WR;
            U_WR:     state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so each pin
    // changes exactly on the edge that enters or leaves its state.
    always_comb begin
        oe_n_d  = (state_d != RD);
        we_n_d  = (state_d != WR_PULSE);
        // SRAM is enabled only in its own states, never alongside the UART.
        en_n_d  = !((state_d == RD) || (state_d == WR_SETUP) || (state_d == WR_PULSE));
        rdn_d   = (state_d != U_RD);
        wrn_d   = (state_d != U_WR);
        // Keep store data on the bus through DONE for hold time after WE/WRN rise.
        drive_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) ||
                  (state_d == U_WR) || ((state_d == DONE) && we_nxt);
    end

    // Control, strobe and load-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            Ram1OE   <= 1'b1;
            Ram1WE   <= 1'b1;
            Ram1EN   <= 1'b1;
            rdn      <= 1'b1;
            wrn      <= 1'b1;
            drive_q  <= 1'b0;
            rdata_o  <= 16'h0000;
            Ram1Addr <= 18'd0;
        end else begin
            state_q  <= state_d;
            Ram1OE   <= oe_n_d;
            Ram1WE   <= we_n_d;
            Ram1EN   <= en_n_d;
            rdn      <= rdn_d;
            wrn      <= wrn_d;
            drive_q  <= drive_d;
            if (accept) begin
                Ram1Addr <= {2'b00, addr_i};
            end
            if (accept && !we_i && (addr_i == UART_STAT_ADDR)) begin
                rdata_o <= uart_status_word(data_ready, tbre, tsre);
            end else if ((state_q == RD) || (state_q == U_RD)) begin
                // Both states always exit to DONE, so this is the read-data edge.
                rdata_o <= Ram1Data;
            end
        end
    end

    // Request capture (data path, no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we_i;
            wdata_q <= wdata_i;
        end
    end

    assign Ram1Data = drive_q ? wdata_q : 16'hzzzz;

    assign done_o = (state_q == DONE);
    assign busy_o = (req_i && !done_o) || ((state_q != IDLE) && (state_q != DONE));

endmodule

// File: tb/tb_dmem_bus.sv
module tb_dmem_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic [15:0] rdata;
    logic        done, busy;
    logic [17:0] ram1_addr;
    wire  [15:0] ram1_data;
    logic        ram1_oe, ram1_we, ram1_en, rdn, wrn;
    logic        data_ready, tbre, tsre;

    always #5 clk = ~clk;

    dmem_bus dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .done_o     (done),
        .busy_o     (busy),
        .Ram1Addr   (ram1_addr),
        .Ram1Data   (ram1_data),
        .Ram1OE     (ram1_oe),
        .Ram1WE     (ram1_we),
        .Ram1EN     (ram1_en),
        .rdn        (rdn),
        .wrn        (wrn),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre)
    );

    // SRAM and UART models driving the shared bus
    logic [15:0] sram [0:65535];
    logic [15:0] uart_rx;
    logic        tb_drv;
    logic [15:0] tb_val;

    always_comb begin
        tb_drv = (!ram1_oe && !ram1_en) || !rdn;
        tb_val = !rdn ? uart_rx : sram[ram1_addr[15:0]];
    end

    assign ram1_data = tb_drv ? tb_val : 16'hzzzz;

    always @(posedge clk) begin
        if (!ram1_en && !ram1_we) sram[ram1_addr[15:0]] <= ram1_data;
    end

    int tests = 0;
    int fails = 0;
    int we_lo = 0, rdn_lo = 0, wrn_lo = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and sample just after the edge; bus ownership rules
    // are checked on every cycle the bench advances.
    task automatic step();
        @(posedge clk);
        #1;
        if (!ram1_oe || !rdn) check("bus_owner", {16'h0, ram1_data}, {16'h0, tb_val});
        if (!rdn || !wrn)     check("en_during_uart", {31'h0, ram1_en}, 32'd1);
        if (!ram1_we) we_lo++;
        if (!rdn)     rdn_lo++;
        if (!wrn)     wrn_lo++;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        dr;
        logic        tbre;
        logic        tsre;
        logic [15:0] rx;
        logic [15:0] exp_rdata;
        int          exp_lat;
        int          exp_we;
        int          exp_rdn;
        int          exp_wrn;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        int          lat;
        int          we_p;
        int          rdn_p;
        int          wrn_p;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[15];

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        bit   got;
        int   we0, rdn0, wrn0;
        exp_t e;
        @(negedge clk);
        data_ready = v.dr;
        tbre       = v.tbre;
        tsre       = v.tsre;
        uart_rx    = v.rx;
        req        = 1'b1;
        we         = v.we;
        addr       = v.addr;
        wdata      = v.wdata;
        exp_q.push_back('{v.exp_rdata, v.exp_lat, v.exp_we, v.exp_rdn, v.exp_wrn});
        we0 = we_lo; rdn0 = rdn_lo; wrn0 = wrn_lo;
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            step();
            lat++;
            if (done) got = 1;
            else check($sformatf("busy_wait[%0d]", idx), {31'h0, busy}, 32'd1);
        end
        if (!got) begin
            check($sformatf("timeout[%0d]", idx), 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            check($sformatf("rdata[%0d]", idx), {16'h0, rdata}, {16'h0, e.rdata});
            check($sformatf("latency[%0d]", idx), lat, e.lat);
            check($sformatf("busy_at_done[%0d]", idx), {31'h0, busy}, 32'd0);
            check($sformatf("we_pulses[%0d]", idx), we_lo - we0, e.we_p);
            check($sformatf("rdn_pulses[%0d]", idx), rdn_lo - rdn0, e.rdn_p);
            check($sformatf("wrn_pulses[%0d]", idx), wrn_lo - wrn0, e.wrn_p);
        end
        req = 1'b0;
        step();
        check($sformatf("done_pulse[%0d]", idx), {31'h0, done}, 32'd0);
        check($sformatf("idle_busy[%0d]", idx), {31'h0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // we addr wdata dr tbre tsre rx exp_rdata lat we rdn wrn
        vecs[0]  = '{1'b1, 16'h0010, 16'hABCD, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 3, 1, 0, 0};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'hABCD, 2, 0, 0, 0};
        vecs[2]  = '{1'b1, 16'h0020, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h0000, 16'hABCD, 3, 1, 0, 0};
        vecs[3]  = '{1'b1, 16'hFFFF, 16'h5A5A, 1'b0, 1'b1, 1'b1, 16'h0000, 16'hABCD, 3, 1, 0, 0};
        vecs[4]  = '{1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1234, 2, 0, 0, 0};
        vecs[5]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h5A5A, 2, 0, 0, 0};
        vecs[6]  = '{1'b0, 16'hBF01, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0002, 1, 0, 0, 0};
        vecs[7]  = '{1'b0, 16'hBF01, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1, 0, 0, 0};
        vecs[8]  = '{1'b1, 16'hBF01, 16'h7777, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0001, 1, 0, 0, 0};
        vecs[9]  = '{1'b1, 16'hBF02, 16'hCAFE, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 3, 1, 0, 0};
        vecs[10] = '{1'b0, 16'hBF02, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'hCAFE, 2, 0, 0, 0};
        vecs[11] = '{1'b0, 16'hBF00, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0055, 16'h0055, 3, 0, 1, 0};
        vecs[12] = '{1'b1, 16'hBF00, 16'h0061, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0055, 3, 0, 0, 1};
        vecs[13] = '{1'b0, 16'hBF01, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0002, 1, 0, 0, 0};
        vecs[14] = '{1'b0, 16'hBF01, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 0, 0, 0};

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0;
        data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1; uart_rx = 16'h0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_strobes", {27'h0, ram1_oe, ram1_we, ram1_en, rdn, wrn}, 32'h1F);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_rdata", {16'h0, rdata}, 32'h0);
        check("rst_addr", {14'h0, ram1_addr}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        step();

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // UART write stalled by a busy transmitter
        @(negedge clk);
        tbre = 1'b0; tsre = 1'b1;
        req = 1'b1; we = 1'b1; addr = 16'hBF00; wdata = 16'h0061;
        for (int i = 0; i < 5; i++) begin
            step();
            check("uw_wait_wrn", {31'h0, wrn}, 32'd1);
            check("uw_wait_en", {31'h0, ram1_en}, 32'd1);
            check("uw_wait_done", {31'h0, done}, 32'd0);
            check("uw_wait_busy", {31'h0, busy}, 32'd1);
        end
        tbre = 1'b1;
        step();
        check("uw_strobe_wrn", {31'h0, wrn}, 32'd0);
        check("uw_strobe_en", {31'h0, ram1_en}, 32'd1);
        check("uw_strobe_bus", {16'h0, ram1_data}, 32'h0061);
        step();
        check("uw_done_wrn", {31'h0, wrn}, 32'd1);
        check("uw_done", {31'h0, done}, 32'd1);
        check("uw_rdata_kept", {16'h0, rdata}, 32'h0000);
        req = 1'b0;
        step();
        check("uw_done_pulse", {31'h0, done}, 32'd0);

        // UART read waiting for a received byte
        @(negedge clk);
        data_ready = 1'b0; uart_rx = 16'h0041;
        req = 1'b1; we = 1'b0; addr = 16'hBF00;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ur_wait_rdn", {31'h0, rdn}, 32'd1);
            check("ur_wait_done", {31'h0, done}, 32'd0);
            check("ur_wait_en", {31'h0, ram1_en}, 32'd1);
        end
        data_ready = 1'b1;
        step();
        check("ur_strobe_rdn", {31'h0, rdn}, 32'd0);
        step();
        check("ur_done_rdn", {31'h0, rdn}, 32'd1);
        check("ur_done", {31'h0, done}, 32'd1);
        check("ur_rdata", {16'h0, rdata}, 32'h0041);
        req = 1'b0; data_ready = 1'b0;
        step();

        // Reset while the SRAM write strobe is low
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'h9999;
        step();
        check("wr_setup_we", {31'h0, ram1_we}, 32'd1);
        check("wr_setup_en", {31'h0, ram1_en}, 32'd0);
        check("wr_setup_bus", {16'h0, ram1_data}, 32'h9999);
        check("wr_setup_addr", {14'h0, ram1_addr}, 32'h30);
        step();
        check("wr_pulse_we", {31'h0, ram1_we}, 32'd0);
        check("wr_pulse_bus", {16'h0, ram1_data}, 32'h9999);
        rst = 1'b1; req = 1'b0;
        step();
        check("abort_strobes", {27'h0, ram1_oe, ram1_we, ram1_en, rdn, wrn}, 32'h1F);
        check("abort_bus_released", {31'h0, (ram1_data === 16'h9999)}, 32'd0);
        check("abort_done", {31'h0, done}, 32'd0);
        check("abort_rdata", {16'h0, rdata}, 32'h0);
        check("abort_addr", {14'h0, ram1_addr}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", {31'h0, done}, 32'd0);
        end
        run_vec(vecs[0], 100);
        run_vec(vecs[1], 101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
